// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, RV32I
// opcode constants, next-PC select encodings and an opcode classifier.
package seq_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [SEL_W-1:0] SEL_PC4    = 2'd0;
  localparam logic [SEL_W-1:0] SEL_BRANCH = 2'd1;
  localparam logic [SEL_W-1:0] SEL_JAL    = 2'd2;

  // Phase-sequencing class of an opcode; R and I-ALU share one path.
  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_SYSTEM,
    C_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [OPC_W-1:0] op);
    op_class_t c;
    case (op)
      OP_R, OP_I: c = C_ALU;
      OP_LOAD:    c = C_LOAD;
      OP_STORE:   c = C_STORE;
      OP_BRANCH:  c = C_BRANCH;
      OP_JAL:     c = C_JAL;
      OP_SYSTEM:  c = C_SYSTEM;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-wait watchdog: counts consecutive cycles spent waiting on mem_ready
// and flags a trip on the cycle the count would reach WDOG_CYCLES.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-low reset
//   i_wait    - FSM is in FETCH/MEM and mem_ready is low this cycle
//   o_trip_c  - combinational trip; this is the WDOG_CYCLES-th wait cycle
module seq_watchdog #(
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_wait,
  output logic o_trip_c
);

  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_cnt;

  // A wait state is only left on mem_ready=1 (or a trip), so clearing on any
  // non-waiting cycle is the same as clearing on entry to FETCH/MEM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_wait) begin
      r_cnt <= r_cnt + WD_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_trip_c = i_wait && (r_cnt == WD_W'(WDOG_CYCLES - 1));

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle control FSM for the single-issue RV32I datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB per opcode, handshakes with memory via mem_ready,
// issues one pc_we per retired instruction and selects the next-PC source.
// Optional feature macro: SEQ_WATCHDOG_EN (bounded wait on mem_ready).
// Ports:
//   clock, reset        - clock (rising) / async active-low reset
//   start               - leave IDLE when high
//   opcode              - instr[6:0], latched on ir_we
//   branch_taken        - ALU compare result, used in EXEC
//   mem_ready           - memory completes request this cycle
//   mem_req, mem_we     - memory request / write strobe
//   ir_we, rf_we, pc_we - IR / register file / PC load enables
//   sel_prox_pc         - 0 pc+4, 1 branch target, 2 jal target
//   estado              - current state encoding
//   halted, erro        - in HALT / sticky error flag
//   instr_count         - retired instruction count (wraps)
module sequenciador_multiciclo
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_we,
  output logic               rf_we,
  output logic               pc_we,
  output logic [SEL_W-1:0]   sel_prox_pc,
  output logic [STATE_W-1:0] estado,
  output logic               halted,
  output logic               erro,
  output logic [CNT_W-1:0]   instr_count
);

  state_t           r_state;
  state_t           w_next;
  logic [OPC_W-1:0] r_opcode;
  logic [CNT_W-1:0] r_count;
  logic             r_erro;
  logic             w_set_erro;
  logic             w_trip;
  op_class_t        w_class;

  assign w_class = classify(r_opcode);

`ifdef SEQ_WATCHDOG_EN
  logic w_wait;

  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

  seq_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clock    (clock),
    .reset    (reset),
    .i_wait   (w_wait),
    .o_trip_c (w_trip)
  );
`else
  // Unbounded wait: no trip source.
  logic w_wdog_unused;

  assign w_wdog_unused = (WDOG_CYCLES == 0);
  assign w_trip        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latched opcode, retired counter and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_opcode <= '0;
      r_count  <= '0;
      r_erro   <= 1'b0;
    end else begin
      if (ir_we) begin
        r_opcode <= opcode;
      end
      if (pc_we) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_set_erro) begin
        r_erro <= 1'b1;
      end
    end
  end

  // Next state and per-state enables.
  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    sel_prox_pc = SEL_PC4;
    halted      = 1'b0;
    w_set_erro  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_trip) begin
          w_next     = S_HALT;
          w_set_erro = 1'b1;
        end
      end

      S_DECODE: begin
        case (w_class)
          C_SYSTEM: w_next = S_HALT;
          C_ILLEGAL: begin
            w_next     = S_HALT;
            w_set_erro = 1'b1;
          end
          default: w_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (w_class)
          C_BRANCH: begin
            pc_we       = 1'b1;
            sel_prox_pc = branch_taken ? SEL_BRANCH : SEL_PC4;
            w_next      = S_FETCH;
          end
          C_LOAD, C_STORE: w_next = S_MEM;
          default:         w_next = S_WB;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_class == C_STORE);
        if (mem_ready) begin
          if (w_class == C_STORE) begin
            pc_we  = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_trip) begin
          w_next     = S_HALT;
          w_set_erro = 1'b1;
        end
      end

      S_WB: begin
        rf_we       = 1'b1;
        pc_we       = 1'b1;
        sel_prox_pc = (w_class == C_JAL) ? SEL_JAL : SEL_PC4;
        w_next      = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign estado      = r_state;
  assign erro        = r_erro;
  assign instr_count = r_count;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Self-checking bench for sequenciador_multiciclo: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against
// a phase-list model of the instruction sequencing.
module tb_sequenciador_multiciclo;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned WDOG  = 16;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3,
                 P_MEM = 4, P_WB = 5, P_HALT = 6;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_SYS = 7'b1110011;
  localparam logic [6:0] T_BAD = 7'b1111111;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req, mem_we, ir_we, rf_we, pc_we, halted, erro;
  logic [1:0]       sel_prox_pc;
  logic [2:0]       estado;
  logic [CNT_W-1:0] instr_count;

  sequenciador_multiciclo #(
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .sel_prox_pc  (sel_prox_pc),
    .estado       (estado),
    .halted       (halted),
    .erro         (erro),
    .instr_count  (instr_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current phase plus the remaining phases of the running instruction.
  int               m_phase;
  logic [6:0]       m_op;
  int               m_rest[$];
  logic [CNT_W-1:0] m_count;
  logic             m_erro;
  int               m_wait;

  logic       e_mem_req, e_mem_we, e_ir_we, e_rf_we, e_pc_we;
  logic [1:0] e_sel;

  logic       o_pc_we, o_rf_we, o_mem_we;
  logic [1:0] o_sel;
  int         tot_pc = 0;
  int         tot_rf = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic bit is_known(input logic [6:0] op);
    return op == T_R || op == T_I || op == T_LD || op == T_ST ||
           op == T_BR || op == T_JAL || op == T_SYS;
  endfunction

  // Phases an instruction visits after FETCH.
  task automatic plan(input logic [6:0] op);
    m_rest.delete();
    case (op)
      T_R, T_I, T_JAL: m_rest = '{P_DEC, P_EXEC, P_WB};
      T_LD:            m_rest = '{P_DEC, P_EXEC, P_MEM, P_WB};
      T_ST:            m_rest = '{P_DEC, P_EXEC, P_MEM};
      T_BR:            m_rest = '{P_DEC, P_EXEC};
      default:         m_rest = '{P_DEC, P_HALT};
    endcase
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_op    = '0;
    m_rest.delete();
    m_count = '0;
    m_erro  = 1'b0;
    m_wait  = 0;
  endtask

  task automatic compute_expected(input logic rdy, input logic bt);
    e_mem_req = (m_phase == P_FETCH) || (m_phase == P_MEM);
    e_mem_we  = (m_phase == P_MEM) && (m_op == T_ST);
    e_ir_we   = (m_phase == P_FETCH) && rdy;
    e_rf_we   = (m_phase == P_WB);
    e_pc_we   = (m_phase == P_WB) || ((m_phase == P_EXEC) && (m_op == T_BR)) ||
                ((m_phase == P_MEM) && (m_op == T_ST) && rdy);
    if ((m_phase == P_EXEC) && (m_op == T_BR) && bt) e_sel = 2'd1;
    else if ((m_phase == P_WB) && (m_op == T_JAL))   e_sel = 2'd2;
    else                                             e_sel = 2'd0;
  endtask

  task automatic advance();
    int nxt;
    if (m_rest.size() == 0) begin
      m_phase = P_FETCH;
    end else begin
      nxt = m_rest.pop_front();
      if (nxt == P_HALT && !is_known(m_op)) m_erro = 1'b1;
      m_phase = nxt;
    end
  endtask

  task automatic model_step(input logic st, input logic [6:0] op, input logic rdy);
    if (e_pc_we) m_count++;
    case (m_phase)
      P_IDLE: if (st) m_phase = P_FETCH;
      P_HALT: ;
      P_FETCH, P_MEM: begin
        if (rdy) begin
          m_wait = 0;
          if (m_phase == P_FETCH) begin
            m_op = op;
            plan(op);
          end
          advance();
        end else begin
          m_wait++;
`ifdef SEQ_WATCHDOG_EN
          if (m_wait == WDOG) begin
            m_phase = P_HALT;
            m_erro  = 1'b1;
            m_rest.delete();
            m_wait  = 0;
          end
`endif
        end
      end
      default: advance();
    endcase
  endtask

  // One clock cycle: drive, compare all outputs against the model, advance.
  task automatic tick(input logic st, input logic [6:0] op, input logic rdy, input logic bt);
    start = st; opcode = op; mem_ready = rdy; branch_taken = bt;
    #2;
    compute_expected(rdy, bt);
    check("estado",      64'(estado),      64'(m_phase));
    check("mem_req",     64'(mem_req),     64'(e_mem_req));
    check("mem_we",      64'(mem_we),      64'(e_mem_we));
    check("ir_we",       64'(ir_we),       64'(e_ir_we));
    check("rf_we",       64'(rf_we),       64'(e_rf_we));
    check("pc_we",       64'(pc_we),       64'(e_pc_we));
    check("sel_prox_pc", 64'(sel_prox_pc), 64'(e_sel));
    check("halted",      64'(halted),      64'(m_phase == P_HALT));
    check("erro",        64'(erro),        64'(m_erro));
    check("instr_count", 64'(instr_count), 64'(m_count));
    o_pc_we = pc_we; o_rf_we = rf_we; o_sel = sel_prox_pc; o_mem_we = mem_we;
    if (pc_we) tot_pc++;
    if (rf_we) tot_rf++;
    @(posedge clock);
    model_step(st, op, rdy);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
    #1;
    check("rst_estado", 64'(estado), 64'd0);
    check("rst_outs",   64'({mem_req, mem_we, ir_we, rf_we, pc_we, halted, erro}), 64'd0);
    check("rst_sel",    64'(sel_prox_pc), 64'd0);
    check("rst_count",  64'(instr_count), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [6:0] rand_op();
    int unsigned r;
    int unsigned k;
    logic [6:0] op;
    r = $urandom_range(0, 99);
    k = $urandom_range(0, 5);
    if (r < 92) begin
      case (k)
        0: op = T_R;
        1: op = T_I;
        2: op = T_LD;
        3: op = T_ST;
        4: op = T_BR;
        default: op = T_JAL;
      endcase
    end else if (r < 96) begin
      op = T_SYS;
    end else begin
      op = 7'($urandom);
    end
    return op;
  endfunction

  initial begin
    int exp_seq[4];
    int mc, pc0, rf0;
    exp_seq = '{1, 2, 3, 5};

    do_reset();

    // R-type with zero-wait memory.
    tick(1'b1, T_R, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("r_state", 64'(estado), 64'(exp_seq[i]));
      tick(1'b0, T_R, 1'b1, 1'b0);
      check("r_pc_we", 64'(o_pc_we), 64'(i == 3));
      check("r_rf_we", 64'(o_rf_we), 64'(i == 3));
    end
    check("r_count", 64'(instr_count), 64'd1);
    check("r_back_fetch", 64'(estado), 64'd1);

    // Load with three wait cycles in MEM.
    pc0 = tot_pc; rf0 = tot_rf; mc = 0;
    repeat (3) tick(1'b0, T_LD, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (estado == 3'd4) mc++;
      tick(1'b0, T_LD, (i == 3), 1'b0);
    end
    check("ld_mem_cycles", 64'(mc), 64'd4);
    check("ld_in_wb", 64'(estado), 64'd5);
    tick(1'b0, T_LD, 1'b1, 1'b0);
    check("ld_pc_once", 64'(tot_pc - pc0), 64'd1);
    check("ld_rf_once", 64'(tot_rf - rf0), 64'd1);
    check("ld_count", 64'(instr_count), 64'd2);

    // Store: write strobe in MEM, no register write.
    rf0 = tot_rf;
    repeat (3) tick(1'b0, T_ST, 1'b1, 1'b0);
    tick(1'b0, T_ST, 1'b1, 1'b0);
    check("st_mem_we", 64'(o_mem_we), 64'd1);
    check("st_pc_we", 64'(o_pc_we), 64'd1);
    check("st_no_rf", 64'(tot_rf - rf0), 64'd0);
    check("st_count", 64'(instr_count), 64'd3);

    // Branch taken / not taken, then jal.
    repeat (2) tick(1'b0, T_BR, 1'b1, 1'b0);
    tick(1'b0, T_BR, 1'b1, 1'b1);
    check("br_t_pc_we", 64'(o_pc_we), 64'd1);
    check("br_t_sel", 64'(o_sel), 64'd1);
    repeat (2) tick(1'b0, T_BR, 1'b1, 1'b1);
    tick(1'b0, T_BR, 1'b1, 1'b0);
    check("br_nt_pc_we", 64'(o_pc_we), 64'd1);
    check("br_nt_sel", 64'(o_sel), 64'd0);
    repeat (3) tick(1'b0, T_JAL, 1'b1, 1'b1);
    tick(1'b0, T_JAL, 1'b1, 1'b1);
    check("jal_sel", 64'(o_sel), 64'd2);
    check("jal_count", 64'(instr_count), 64'd6);

    // Asynchronous reset in the middle of MEM.
    repeat (3) tick(1'b0, T_LD, 1'b1, 1'b0);
    tick(1'b0, T_LD, 1'b0, 1'b0);
    check("mid_mem", 64'(estado), 64'd4);
    reset = 1'b0;
    #1;
    check("arst_estado", 64'(estado), 64'd0);
    check("arst_count", 64'(instr_count), 64'd0);
    check("arst_enables", 64'({mem_req, mem_we, pc_we, rf_we, ir_we}), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // System halts cleanly; start toggling does not leave HALT.
    tick(1'b1, T_SYS, 1'b1, 1'b0);
    repeat (2) tick(1'b0, T_SYS, 1'b1, 1'b0);
    check("sys_halt", 64'(estado), 64'd6);
    check("sys_halted", 64'(halted), 64'd1);
    check("sys_erro", 64'(erro), 64'd0);
    for (int i = 0; i < 6; i++) tick(1'(i % 2), T_SYS, 1'b1, 1'b0);
    check("sys_sticky", 64'(estado), 64'd6);

    // Illegal opcode halts with error.
    do_reset();
    tick(1'b1, T_BAD, 1'b1, 1'b0);
    repeat (2) tick(1'b0, T_BAD, 1'b1, 1'b0);
    check("bad_halted", 64'(halted), 64'd1);
    check("bad_erro", 64'(erro), 64'd1);

    // mem_ready stuck low in FETCH.
    do_reset();
    tick(1'b1, T_R, 1'b0, 1'b0);
    repeat (15) tick(1'b0, T_R, 1'b0, 1'b0);
    check("wd_still_fetch", 64'(estado), 64'd1);
    tick(1'b0, T_R, 1'b0, 1'b0);
`ifdef SEQ_WATCHDOG_EN
    check("wd_trip_state", 64'(estado), 64'd6);
    check("wd_trip_erro", 64'(erro), 64'd1);
    check("wd_no_pc", 64'(instr_count), 64'd0);
`else
    repeat (24) tick(1'b0, T_R, 1'b0, 1'b0);
    check("nowd_fetch", 64'(estado), 64'd1);
    check("nowd_erro", 64'(erro), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        tick($urandom_range(0, 3) != 0, rand_op(),
             $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
